// File: rtl/ysyx_24100005_ctrl_pkg.sv
// rtl/ysyx_24100005_ctrl_pkg.sv - shared state encoding and constants for the core sequencer
package ysyx_24100005_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_INST = 3'd2,
    EXEC      = 3'd3,
    WB        = 3'd4,
    HALT      = 3'd5,
    ERR       = 3'd6
  } ctrl_state_e;

  localparam logic [6:0] OPC_SYSTEM      = 7'b1110011;
  localparam int         DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/ysyx_24100005_fetch_wdt.sv
// rtl/ysyx_24100005_fetch_wdt.sv - fetch wait watchdog; expired flags the last permitted wait cycle
import ysyx_24100005_ctrl_pkg::*;

module ysyx_24100005_fetch_wdt #(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_24100005_cpu_ctrl.sv
// rtl/ysyx_24100005_cpu_ctrl.sv - fetch/exec/writeback sequencer with IR and write-enable gating
// Optional perf counters: define YSYX_24100005_PERF_CNT_EN to build mcycle/minstret.
import ysyx_24100005_ctrl_pkg::*;

module ysyx_24100005_cpu_ctrl #(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        pc_wen,
  input  logic        rf_wen_req,
  output logic        rf_wen,
  input  logic        is_ebreak,
  output logic        retire,
  output logic        halted,
  output logic        err,
  output logic [63:0] mcycle,
  output logic [63:0] minstret
);

  ctrl_state_e state, next_state;
  logic        ir_load;
  logic        wdt_clear;
  logic        wdt_en;
  logic        wdt_expired;

  ysyx_24100005_fetch_wdt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdt (
    .clk     (clk),
    .rst     (rst),
    .clear   (wdt_clear),
    .enable  (wdt_en),
    .expired (wdt_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      inst  <= 32'h0;
    end else begin
      state <= next_state;
      if (ir_load) inst <= imem_rdata;
    end
  end

  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    pc_wen     = 1'b0;
    rf_wen     = 1'b0;
    retire     = 1'b0;
    ir_load    = 1'b0;
    wdt_clear  = 1'b0;
    wdt_en     = 1'b0;
    case (state)
      IDLE: next_state = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid) begin
          ir_load    = 1'b1;
          next_state = EXEC;
        end else begin
          wdt_clear  = 1'b1;
          next_state = WAIT_INST;
        end
      end
      WAIT_INST: begin
        if (imem_rvalid) begin
          ir_load    = 1'b1;
          wdt_clear  = 1'b1;
          next_state = EXEC;
        end else if (wdt_expired) begin
          next_state = ERR;
        end else begin
          wdt_en = 1'b1;
        end
      end
      // decode/adder settle; ebreak leaves without writeback so it never retires
      EXEC: next_state = is_ebreak ? HALT : WB;
      WB: begin
        pc_wen     = 1'b1;
        rf_wen     = rf_wen_req;
        retire     = 1'b1;
        next_state = FETCH;
      end
      HALT:    next_state = HALT;
      ERR:     next_state = ERR;
      default: next_state = IDLE;
    endcase
  end

  assign halted = (state == HALT);
  assign err    = (state == ERR);

`ifdef YSYX_24100005_PERF_CNT_EN
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      mcycle_q <= mcycle_q + 64'd1;
      if (retire) minstret_q <= minstret_q + 64'd1;
    end
  end

  assign mcycle   = mcycle_q;
  assign minstret = minstret_q;
`else
  assign mcycle   = 64'h0;
  assign minstret = 64'h0;
`endif

endmodule

// File: tb/tb_ysyx_24100005_cpu_ctrl.sv
// tb/tb_ysyx_24100005_cpu_ctrl.sv - self-checking bench for the core sequencer
module tb_ysyx_24100005_cpu_ctrl;

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] SW   = 32'h00112023;
  localparam logic [31:0] EBRK = 32'h00100073;
  localparam logic [31:0] JUNK = 32'hDEADBEEF;
  localparam logic [31:0] STALE = 32'h12345678;

`ifdef YSYX_24100005_PERF_CNT_EN
  localparam logic [63:0] EXP_MCYCLE   = 64'd31;
  localparam logic [63:0] EXP_MINSTRET = 64'd10;
`else
  localparam logic [63:0] EXP_MCYCLE   = 64'd0;
  localparam logic [63:0] EXP_MINSTRET = 64'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] inst;
  logic        pc_wen;
  logic        rf_wen_req = 1'b0;
  logic        rf_wen;
  logic        is_ebreak = 1'b0;
  logic        retire;
  logic        halted;
  logic        err;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  ysyx_24100005_cpu_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .pc_wen      (pc_wen),
    .rf_wen_req  (rf_wen_req),
    .rf_wen      (rf_wen),
    .is_ebreak   (is_ebreak),
    .retire      (retire),
    .halted      (halted),
    .err         (err),
    .mcycle      (mcycle),
    .minstret    (minstret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rvalid;
    logic [31:0] rdata;
    logic        wen_req;
    logic        ebreak;
    logic        e_req;
    logic        e_pc;
    logic        e_rf;
    logic        e_ret;
    logic        e_halt;
    logic        e_err;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[13];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; rf_wen_req = 1'b0; is_ebreak = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic rv, input logic [31:0] rd, input logic wr, input logic eb,
                              input logic rq, input logic pc, input logic rf, input logic rt,
                              input logic h, input logic e, input logic [31:0] ins);
    vec_t v;
    v.rvalid = rv; v.rdata = rd; v.wen_req = wr; v.ebreak = eb;
    v.e_req = rq; v.e_pc = pc; v.e_rf = rf; v.e_ret = rt;
    v.e_halt = h; v.e_err = e; v.e_inst = ins;
    return v;
  endfunction

  initial begin
    int   req_cnt;
    int   err_cyc;
    int   bad;
    int   ret_cnt;
    vec_t got;

    //           rv  rdata wr eb  req pc rf ret h  e  inst
    vecs[0]  = mk(1, ADDI, 1, 0,  0, 0, 0, 0, 0, 0, 32'h0);  // IDLE
    vecs[1]  = mk(1, ADDI, 1, 0,  1, 0, 0, 0, 0, 0, 32'h0);  // FETCH, zero-wait
    vecs[2]  = mk(1, ADDI, 1, 0,  0, 0, 0, 0, 0, 0, ADDI);   // EXEC
    vecs[3]  = mk(1, ADDI, 1, 0,  0, 1, 1, 1, 0, 0, ADDI);   // WB
    vecs[4]  = mk(0, JUNK, 0, 0,  1, 0, 0, 0, 0, 0, ADDI);   // FETCH, miss
    vecs[5]  = mk(0, JUNK, 0, 0,  0, 0, 0, 0, 0, 0, ADDI);   // WAIT 1
    vecs[6]  = mk(1, SW,   0, 0,  0, 0, 0, 0, 0, 0, ADDI);   // WAIT 2, data
    vecs[7]  = mk(1, JUNK, 0, 0,  0, 0, 0, 0, 0, 0, SW);     // EXEC, stray rvalid
    vecs[8]  = mk(1, JUNK, 0, 0,  0, 1, 0, 1, 0, 0, SW);     // WB, rf_wen_req=0
    vecs[9]  = mk(1, EBRK, 1, 0,  1, 0, 0, 0, 0, 0, SW);     // FETCH ebreak
    vecs[10] = mk(0, JUNK, 1, 1,  0, 0, 0, 0, 0, 0, EBRK);   // EXEC ebreak
    vecs[11] = mk(1, JUNK, 1, 1,  0, 0, 0, 0, 1, 0, EBRK);   // HALT
    vecs[12] = mk(1, JUNK, 1, 1,  0, 0, 0, 0, 1, 0, EBRK);   // HALT

    // reset state
    @(negedge clk);
    chk("reset_outs", {59'h0, imem_req, pc_wen, rf_wen, retire, halted, err}, 64'h0);
    chk("reset_inst", {32'h0, inst}, 64'h0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      imem_rvalid = vecs[i].rvalid;
      imem_rdata  = vecs[i].rdata;
      rf_wen_req  = vecs[i].wen_req;
      is_ebreak   = vecs[i].ebreak;
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      got = exp_q.pop_front();
      chk($sformatf("c%0d_ctl", i), {58'h0, imem_req, pc_wen, rf_wen, retire, halted, err},
          {58'h0, got.e_req, got.e_pc, got.e_rf, got.e_ret, got.e_halt, got.e_err});
      chk($sformatf("c%0d_inst", i), {32'h0, inst}, {32'h0, got.e_inst});
      next_cycle();
    end

    // halted holds for 100 cycles with all enables low
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({halted, imem_req, pc_wen, rf_wen, retire, err} !== 6'b100000) bad++;
      next_cycle();
    end
    chk("halt_hold", 64'(bad), 64'd0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("halt_cleared", {63'h0, halted}, 64'h0);
    chk("halt_rst_inst", {32'h0, inst}, 64'h0);

    // fetch timeout: rvalid never arrives
    do_reset();
    req_cnt = 0;
    err_cyc = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (imem_req) req_cnt++;
      if (err) begin
        err_cyc = c;
        break;
      end
      next_cycle();
    end
    chk("timeout_cycle", 64'(err_cyc), 64'd18);
    chk("timeout_reqs", 64'(req_cnt), 64'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      @(negedge clk);
      if (!err || imem_req || pc_wen || rf_wen) bad++;
    end
    chk("err_sticky", 64'(bad), 64'd0);

    // perf counters over 10 zero-wait instructions
    do_reset();
    imem_rvalid = 1'b1; imem_rdata = ADDI; rf_wen_req = 1'b1;
    ret_cnt = 0;
    for (int c = 0; c < 31; c++) begin
      @(negedge clk);
      if (retire) ret_cnt++;
      next_cycle();
    end
    imem_rvalid = 1'b0;
    @(negedge clk);
    chk("retire_count", 64'(ret_cnt), 64'd10);
    chk("mcycle", mcycle, EXP_MCYCLE);
    chk("minstret", minstret, EXP_MINSTRET);

    // reset mid-WAIT_INST, then stale rvalid while in IDLE
    next_cycle();
    @(negedge clk);
    chk("wait_no_req", {63'h0, imem_req}, 64'h0);
    rst = 1'b1;
    #1;
    chk("midrst_inst", {32'h0, inst}, 64'h0);
    chk("midrst_mcycle", mcycle, 64'h0);
    next_cycle();
    rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = STALE;
    @(negedge clk);
    chk("idle_no_req", {63'h0, imem_req}, 64'h0);
    next_cycle();
    imem_rvalid = 1'b0;
    @(negedge clk);
    chk("stale_fetch_req", {63'h0, imem_req}, 64'h1);
    chk("stale_inst", {32'h0, inst}, 64'h0);
    next_cycle();
    @(negedge clk);
    chk("stale_wait_inst", {32'h0, inst}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
